updown_counter_sat: RTL and testbench
=====================================

Name: updown_counter_sat

Overview:
- Parametrised up/down counter with variable step size, synchronous clear and load, and per-direction saturate-or-wrap mode.
- Provides programmable level flags plus overflow/underflow event pulses.
- Intended as the general occupancy/credit counter for NoC router buffers and FIFO fill tracking. Replaces fixed-step, free-running counters.

Parameters:
- CNT_W, 8, counter width in bits
- STEP_W, 4, width of step_i
- MIN_VAL, 0, lowest legal count
- MAX_VAL, 255, highest legal count (MIN_VAL < MAX_VAL <= 2^CNT_W-1)
- RST_VAL, 0, count after reset/clear (MIN_VAL..MAX_VAL)
- SAT_HIGH, 1, 1 = saturate at MAX_VAL; 0 = wrap to low end of range
- SAT_LOW, 1, 1 = saturate at MIN_VAL; 0 = wrap to high end of range
- AE_LVL, 10, almost_empty threshold (count <= AE_LVL)
- AF_LVL, 250, almost_full threshold (count >= AF_LVL)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- clr_i  in  1  synchronous clear to RST_VAL
- load_i  in  1  synchronous load of load_val_i
- load_val_i  in  CNT_W  load value
- inc_i  in  1  increment request
- dec_i  in  1  decrement request
- step_i  in  STEP_W  step magnitude for inc/dec
- count_o  out  CNT_W  registered count
- full_o  out  1  count == MAX_VAL
- empty_o  out  1  count == MIN_VAL
- almost_full_o  out  1  count >= AF_LVL
- almost_empty_o  out  1  count <= AE_LVL
- ovf_o  out  1  one-cycle pulse: increment exceeded MAX_VAL
- unf_o  out  1  one-cycle pulse: decrement went below MIN_VAL
- err_o  out  1  sticky error (see Optional Feature)

Behaviour:
- Reset (async, rst_ni low): count_o = RST_VAL; ovf_o = unf_o = err_o = 0. Level flags follow count_o.
- Priority per clock is clr_i > load_i > inc/dec.
- clr_i: count = RST_VAL; ovf_o = unf_o = 0 next cycle.
- load_i: count = load_val_i clamped to [MIN_VAL, MAX_VAL]. No ovf/unf is raised on a clamp.
- inc_i & dec_i both high, or step_i == 0: count holds; no pulse.
- Arithmetic is done in CNT_W+2 bits, signed-safe; no intermediate truncation.
- Range R = MAX_VAL - MIN_VAL + 1. step_i must be <= R-1; larger values are out of contract.
- Increment, nxt = count + step:
  - nxt <= MAX_VAL: count = nxt.
  - nxt > MAX_VAL, SAT_HIGH = 1: count = MAX_VAL; ovf_o = 1.
  - nxt > MAX_VAL, SAT_HIGH = 0: count = nxt - R; ovf_o = 1.
- Decrement, nxt = count - step:
  - nxt >= MIN_VAL: count = nxt.
  - nxt < MIN_VAL, SAT_LOW = 1: count = MIN_VAL; unf_o = 1.
  - nxt < MIN_VAL, SAT_LOW = 0: count = nxt + R; unf_o = 1.
- Saturated hold: incrementing while already at MAX_VAL (or decrementing at MIN_VAL) still pulses ovf_o/unf_o every such cycle.
- ovf_o and unf_o are registered. They are high in the same cycle count_o shows the post-event value, and cleared the following cycle unless the event repeats.
- full_o, empty_o, almost_full_o and almost_empty_o are combinational from the count register: zero latency relative to count_o, glitch-free.
- Reset asserted mid-operation overrides everything immediately. Behaviour on the first edge after release is normal.

Optional Feature:
- Macro: UPDOWN_CNT_STICKY_ERR_EN.
- Defined: err_o is set on any cycle where ovf_o or unf_o is set. It holds until clr_i or reset; load_i does not clear it.
- Undefined: err_o is tied to 0 and no sticky register is built.

Test Plan:
- Reset with RST_VAL = 0 -> count_o = 0, empty_o = 1, almost_empty_o = 1, full_o = 0, ovf_o = unf_o = 0.
- SAT_HIGH = 1, load 250, inc with step 4 twice -> 254 then 255. Second cycle ovf_o = 1; full_o = 1; almost_full_o = 1 from 250 onward.
- SAT_HIGH = 0, MIN = 0, MAX = 255, count 253, inc step 5 -> count_o = 2, ovf_o = 1 for one cycle. UPDOWN_CNT_STICKY_ERR_EN defined: err_o stays 1 until clr_i.
- SAT_LOW = 0, MIN = 4, MAX = 19, count 5, dec step 3 -> count_o = 18, unf_o = 1.
- inc_i = dec_i = 1 with step 7 at count 100 -> count holds 100, no pulse.
- Same-cycle clr_i + load_i(77) + inc_i -> count_o = RST_VAL.
- load_val_i = 300 with CNT_W = 9, MAX = 255 -> count_o = 255, ovf_o = 0.

Source files
------------

// File: rtl/updown_counter_sat_if.sv
// Control and status bundle for updown_counter_sat: clear/load/step requests in,
// registered count plus level flags and overflow/underflow events out.
interface updown_counter_sat_if #(
   parameter int CNT_W  = 8,
   parameter int STEP_W = 4
);
   logic              clr_i;
   logic              load_i;
   logic [CNT_W-1:0]  load_val_i;
   logic              inc_i;
   logic              dec_i;
   logic [STEP_W-1:0] step_i;
   logic [CNT_W-1:0]  count_o;
   logic              full_o;
   logic              empty_o;
   logic              almost_full_o;
   logic              almost_empty_o;
   logic              ovf_o;
   logic              unf_o;
   logic              err_o;

   modport master (
      output clr_i, load_i, load_val_i, inc_i, dec_i, step_i,
      input  count_o, full_o, empty_o, almost_full_o, almost_empty_o, ovf_o, unf_o, err_o
   );

   modport slave (
      input  clr_i, load_i, load_val_i, inc_i, dec_i, step_i,
      output count_o, full_o, empty_o, almost_full_o, almost_empty_o, ovf_o, unf_o, err_o
   );
endinterface

// File: rtl/updown_counter_sat.sv
// Up/down occupancy counter with variable step, clamp-on-load and per-direction saturate/wrap.
// Optional sticky error flag built only when UPDOWN_CNT_STICKY_ERR_EN is defined.
module updown_counter_sat #(
   parameter int CNT_W    = 8,
   parameter int STEP_W   = 4,
   parameter int MIN_VAL  = 0,
   parameter int MAX_VAL  = 255,
   parameter int RST_VAL  = 0,
   parameter int SAT_HIGH = 1,
   parameter int SAT_LOW  = 1,
   parameter int AE_LVL   = 10,
   parameter int AF_LVL   = 250
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   updown_counter_sat_if.slave bus
);
   // Two guard bits keep count +/- step exact, including negative results.
   localparam int W = CNT_W + 2;
   typedef logic signed [W-1:0] wide_t;

   localparam wide_t MIN_W   = wide_t'(MIN_VAL);
   localparam wide_t MAX_W   = wide_t'(MAX_VAL);
   localparam wide_t RANGE_W = wide_t'(MAX_VAL - MIN_VAL + 1);

   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_VAL);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);
   localparam logic [CNT_W-1:0] RST_C = CNT_W'(RST_VAL);
   localparam logic [CNT_W-1:0] AE_C  = CNT_W'(AE_LVL);
   localparam logic [CNT_W-1:0] AF_C  = CNT_W'(AF_LVL);

   logic [CNT_W-1:0] count, count_nxt;
   logic             ovf, ovf_nxt;
   logic             unf, unf_nxt;
   wide_t            cur, stp, up, dn;
   logic             step_nz;

   assign cur     = wide_t'({2'b00, count});
   assign stp     = wide_t'(bus.step_i);
   assign up      = cur + stp;
   assign dn      = cur - stp;
   assign step_nz = (bus.step_i != '0);

   always_comb begin
      count_nxt = count;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
      if (bus.clr_i) begin
         count_nxt = RST_C;
      end else if (bus.load_i) begin
         if (bus.load_val_i > MAX_C)
            count_nxt = MAX_C;
         else if (bus.load_val_i < MIN_C)
            count_nxt = MIN_C;
         else
            count_nxt = bus.load_val_i;
      end else if (bus.inc_i && !bus.dec_i && step_nz) begin
         if (up > MAX_W) begin
            ovf_nxt   = 1'b1;
            count_nxt = (SAT_HIGH != 0) ? MAX_C : CNT_W'(up - RANGE_W);
         end else begin
            count_nxt = CNT_W'(up);
         end
      end else if (bus.dec_i && !bus.inc_i && step_nz) begin
         if (dn < MIN_W) begin
            unf_nxt   = 1'b1;
            count_nxt = (SAT_LOW != 0) ? MIN_C : CNT_W'(dn + RANGE_W);
         end else begin
            count_nxt = CNT_W'(dn);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count <= RST_C;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         count <= count_nxt;
         ovf   <= ovf_nxt;
         unf   <= unf_nxt;
      end
   end

`ifdef UPDOWN_CNT_STICKY_ERR_EN
   logic err;

   // Set alongside the event pulse so err_o rises in the same cycle as ovf_o/unf_o.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         err <= 1'b0;
      else if (bus.clr_i)
         err <= 1'b0;
      else if (ovf_nxt || unf_nxt)
         err <= 1'b1;
   end

   assign bus.err_o = err;
`else
   assign bus.err_o = 1'b0;
`endif

   assign bus.count_o        = count;
   assign bus.ovf_o          = ovf;
   assign bus.unf_o          = unf;
   assign bus.full_o         = (count == MAX_C);
   assign bus.empty_o        = (count == MIN_C);
   assign bus.almost_full_o  = (count >= AF_C);
   assign bus.almost_empty_o = (count <= AE_C);
endmodule

// File: tb/tb_updown_counter_sat.sv
// Directed bench for updown_counter_sat: three parameterisations share one clock/reset,
// a vector table exercises the default build, hand sequences cover wrap, clamp and reset.
module tb_updown_counter_sat;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

`ifdef UPDOWN_CNT_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   always #5 clk = ~clk;

   updown_counter_sat_if #(.CNT_W(8), .STEP_W(4)) ifa ();
   updown_counter_sat_if #(.CNT_W(5), .STEP_W(4)) ifb ();
   updown_counter_sat_if #(.CNT_W(9), .STEP_W(4)) ifc ();

   updown_counter_sat #(
      .CNT_W(8), .STEP_W(4), .MIN_VAL(0), .MAX_VAL(255), .RST_VAL(0),
      .SAT_HIGH(1), .SAT_LOW(1), .AE_LVL(10), .AF_LVL(250)
   ) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));

   updown_counter_sat #(
      .CNT_W(5), .STEP_W(4), .MIN_VAL(4), .MAX_VAL(19), .RST_VAL(4),
      .SAT_HIGH(0), .SAT_LOW(0), .AE_LVL(6), .AF_LVL(17)
   ) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));

   updown_counter_sat #(
      .CNT_W(9), .STEP_W(4), .MIN_VAL(0), .MAX_VAL(255), .RST_VAL(0),
      .SAT_HIGH(0), .SAT_LOW(1), .AE_LVL(10), .AF_LVL(250)
   ) dut_c (.clk_i(clk), .rst_ni(rst_n), .bus(ifc));

   typedef struct {
      logic       clr, load;
      logic [7:0] lval;
      logic       inc, dec;
      logic [3:0] step;
      logic [7:0] cnt;
      logic       ovf, unf, full, empty, af, ae;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic clr, input logic load, input int lval,
                               input logic inc, input logic dec, input int step,
                               input int cnt, input logic ovf, input logic unf,
                               input logic full, input logic empty, input logic af,
                               input logic ae);
      vec_t v;
      v.clr = clr; v.load = load; v.lval = 8'(lval); v.inc = inc; v.dec = dec;
      v.step = 4'(step); v.cnt = 8'(cnt); v.ovf = ovf; v.unf = unf;
      v.full = full; v.empty = empty; v.af = af; v.ae = ae;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic drive_b(input logic clr, input logic load, input int lval,
                          input logic inc, input logic dec, input int step);
      ifb.clr_i = clr; ifb.load_i = load; ifb.load_val_i = 5'(lval);
      ifb.inc_i = inc; ifb.dec_i = dec; ifb.step_i = 4'(step);
   endtask

   task automatic drive_c(input logic clr, input logic load, input int lval,
                          input logic inc, input logic dec, input int step);
      ifc.clr_i = clr; ifc.load_i = load; ifc.load_val_i = 9'(lval);
      ifc.inc_i = inc; ifc.dec_i = dec; ifc.step_i = 4'(step);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic err_m;

   initial begin
      vecs[0]  = mk(0, 1, 250, 0, 0, 0,  250, 0, 0, 0, 0, 1, 0);
      vecs[1]  = mk(0, 0, 0,   1, 0, 4,  254, 0, 0, 0, 0, 1, 0);
      vecs[2]  = mk(0, 0, 0,   1, 0, 4,  255, 1, 0, 1, 0, 1, 0);
      vecs[3]  = mk(0, 0, 0,   1, 0, 1,  255, 1, 0, 1, 0, 1, 0);
      vecs[4]  = mk(0, 0, 0,   0, 0, 0,  255, 0, 0, 1, 0, 1, 0);
      vecs[5]  = mk(0, 1, 100, 0, 0, 0,  100, 0, 0, 0, 0, 0, 0);
      vecs[6]  = mk(0, 0, 0,   1, 1, 7,  100, 0, 0, 0, 0, 0, 0);
      vecs[7]  = mk(0, 0, 0,   1, 0, 0,  100, 0, 0, 0, 0, 0, 0);
      vecs[8]  = mk(1, 1, 77,  1, 0, 3,  0,   0, 0, 0, 1, 0, 1);
      vecs[9]  = mk(0, 1, 77,  1, 0, 3,  77,  0, 0, 0, 0, 0, 0);
      vecs[10] = mk(0, 0, 0,   0, 1, 15, 62,  0, 0, 0, 0, 0, 0);
      vecs[11] = mk(0, 1, 5,   0, 0, 0,  5,   0, 0, 0, 0, 0, 1);
      vecs[12] = mk(0, 0, 0,   0, 1, 7,  0,   0, 1, 0, 1, 0, 1);
      vecs[13] = mk(0, 0, 0,   0, 1, 1,  0,   0, 1, 0, 1, 0, 1);
      vecs[14] = mk(0, 0, 0,   1, 0, 10, 10,  0, 0, 0, 0, 0, 1);
      vecs[15] = mk(0, 0, 0,   1, 0, 1,  11,  0, 0, 0, 0, 0, 0);
      vecs[16] = mk(0, 1, 249, 0, 0, 0,  249, 0, 0, 0, 0, 0, 0);
      vecs[17] = mk(0, 0, 0,   1, 0, 1,  250, 0, 0, 0, 0, 1, 0);
      vecs[18] = mk(0, 1, 251, 0, 0, 0,  251, 0, 0, 0, 0, 1, 0);
      vecs[19] = mk(0, 0, 0,   1, 0, 4,  255, 0, 0, 1, 0, 1, 0);
      vecs[20] = mk(1, 0, 0,   0, 0, 0,  0,   0, 0, 0, 1, 0, 1);
      vecs[21] = mk(0, 0, 0,   1, 0, 15, 15,  0, 0, 0, 0, 0, 0);

      ifa.clr_i = 0; ifa.load_i = 0; ifa.load_val_i = '0;
      ifa.inc_i = 0; ifa.dec_i = 0; ifa.step_i = '0;
      drive_b(0, 0, 0, 0, 0, 0);
      drive_c(0, 0, 0, 0, 0, 0);

      #12;
      chk("reset count",        int'(ifa.count_o), 0);
      chk("reset empty",        int'(ifa.empty_o), 1);
      chk("reset almost_empty", int'(ifa.almost_empty_o), 1);
      chk("reset full",         int'(ifa.full_o), 0);
      chk("reset ovf",          int'(ifa.ovf_o), 0);
      chk("reset unf",          int'(ifa.unf_o), 0);
      chk("reset err",          int'(ifa.err_o), 0);
      chk("reset b count",      int'(ifb.count_o), 4);

      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      err_m = 1'b0;
      for (int i = 0; i < NV; i++) begin
         ifa.clr_i = vecs[i].clr; ifa.load_i = vecs[i].load; ifa.load_val_i = vecs[i].lval;
         ifa.inc_i = vecs[i].inc; ifa.dec_i = vecs[i].dec;  ifa.step_i = vecs[i].step;
         tick();
         err_m = vecs[i].clr ? 1'b0 : (err_m | vecs[i].ovf | vecs[i].unf);
         chk($sformatf("a[%0d] count", i), int'(ifa.count_o), int'(vecs[i].cnt));
         chk($sformatf("a[%0d] ovf", i),   int'(ifa.ovf_o),   int'(vecs[i].ovf));
         chk($sformatf("a[%0d] unf", i),   int'(ifa.unf_o),   int'(vecs[i].unf));
         chk($sformatf("a[%0d] flags", i),
             int'({ifa.full_o, ifa.empty_o, ifa.almost_full_o, ifa.almost_empty_o}),
             int'({vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae}));
         chk($sformatf("a[%0d] err", i), int'(ifa.err_o), int'(STICKY & err_m));
      end
      ifa.clr_i = 0; ifa.load_i = 0; ifa.inc_i = 0; ifa.dec_i = 0; ifa.step_i = '0;

      // Range 4..19, both directions wrap (R = 16).
      drive_b(0, 1, 5, 0, 0, 0); tick();
      chk("b load 5", int'(ifb.count_o), 5);
      drive_b(0, 0, 0, 0, 1, 3); tick();
      chk("b wrap dec count", int'(ifb.count_o), 18);
      chk("b wrap dec unf",   int'(ifb.unf_o), 1);
      chk("b af at 18",       int'(ifb.almost_full_o), 1);
      drive_b(0, 0, 0, 1, 0, 3); tick();
      chk("b wrap inc count", int'(ifb.count_o), 5);
      chk("b wrap inc ovf",   int'(ifb.ovf_o), 1);
      chk("b wrap inc unf",   int'(ifb.unf_o), 0);
      drive_b(0, 0, 0, 0, 1, 1); tick();
      chk("b dec to min",     int'(ifb.count_o), 4);
      chk("b dec to min unf", int'(ifb.unf_o), 0);
      chk("b empty",          int'(ifb.empty_o), 1);
      chk("b err sticky",     int'(ifb.err_o), int'(STICKY));
      drive_b(0, 1, 25, 0, 0, 0); tick();
      chk("b clamp high",     int'(ifb.count_o), 19);
      chk("b clamp full",     int'(ifb.full_o), 1);
      chk("b clamp no ovf",   int'(ifb.ovf_o), 0);
      drive_b(0, 1, 0, 0, 0, 0); tick();
      chk("b clamp low",      int'(ifb.count_o), 4);
      chk("b clamp no unf",   int'(ifb.unf_o), 0);
      chk("b load keeps err", int'(ifb.err_o), int'(STICKY));
      drive_b(1, 0, 0, 0, 0, 0); tick();
      chk("b clr err",        int'(ifb.err_o), 0);
      drive_b(0, 0, 0, 0, 0, 0);

      // 9-bit counter limited to 0..255, high side wraps.
      drive_c(0, 1, 300, 0, 0, 0); tick();
      chk("c clamp 300",     int'(ifc.count_o), 255);
      chk("c clamp ovf",     int'(ifc.ovf_o), 0);
      chk("c clamp full",    int'(ifc.full_o), 1);
      drive_c(0, 1, 253, 0, 0, 0); tick();
      drive_c(0, 0, 0, 1, 0, 5); tick();
      chk("c wrap count",    int'(ifc.count_o), 2);
      chk("c wrap ovf",      int'(ifc.ovf_o), 1);
      chk("c wrap err",      int'(ifc.err_o), int'(STICKY));
      drive_c(0, 0, 0, 0, 0, 0); tick();
      chk("c ovf drops",     int'(ifc.ovf_o), 0);
      chk("c hold count",    int'(ifc.count_o), 2);
      chk("c err holds",     int'(ifc.err_o), int'(STICKY));
      tick();
      chk("c err holds 2",   int'(ifc.err_o), int'(STICKY));
      drive_c(1, 0, 0, 0, 0, 0); tick();
      chk("c clr count",     int'(ifc.count_o), 0);
      chk("c clr err",       int'(ifc.err_o), 0);
      drive_c(0, 0, 0, 0, 1, 2); tick();
      chk("c sat low count", int'(ifc.count_o), 0);
      chk("c sat low unf",   int'(ifc.unf_o), 1);
      drive_c(0, 0, 0, 0, 0, 0);

      // Asynchronous reset mid-cycle, then normal behaviour on the first edge after release.
      drive_b(0, 1, 15, 0, 0, 0); tick();
      drive_b(0, 0, 0, 0, 0, 0);
      chk("b pre-reset", int'(ifb.count_o), 15);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async reset b count", int'(ifb.count_o), 4);
      chk("async reset c unf",   int'(ifc.unf_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_b(0, 0, 0, 1, 0, 2); tick();
      chk("b after reset inc", int'(ifb.count_o), 6);
      chk("b after reset ae",  int'(ifb.almost_empty_o), 1);
      drive_b(0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
